// File: rtl/ternary_dot_pkg.sv
`default_nettype none
//==============================================================================
// ternary_dot_pkg: bus phase codes, weight codes, FSM states and popcount helper
// Rev 1.0
//==============================================================================
package ternary_dot_pkg;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_X    = 2'b01;
  localparam logic [1:0] PH_W    = 2'b10;

  localparam logic [1:0] W_ZERO  = 2'b00;
  localparam logic [1:0] W_POS   = 2'b01;
  localparam logic [1:0] W_NEG   = 2'b11;

  localparam int RES_BITS = 13;
  localparam int OUT_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ternary_dot_ref.sv
`default_nettype none
//==============================================================================
// ternary_dot_ref: golden signed ternary dot product, one popcount per 32-element slice
// Rev 1.0
//==============================================================================
module ternary_dot_ref
  import ternary_dot_pkg::*;
#(
  parameter int N_ELEMS = 32
) (
  input  logic [N_ELEMS-1:0]  x,
  input  logic [N_ELEMS-1:0]  w_pos,
  input  logic [N_ELEMS-1:0]  w_neg,
  output logic [OUT_BITS-1:0] expected
);

  localparam int SLICES = (N_ELEMS + 31) / 32;
  localparam int PAD    = SLICES * 32;

  logic [PAD-1:0]      x_p;
  logic [PAD-1:0]      p_p;
  logic [PAD-1:0]      n_p;
  logic [5:0]          pos_cnt [SLICES];
  logic [5:0]          neg_cnt [SLICES];
  logic [OUT_BITS-1:0] sum;

  // Zero padding makes the tail slice contribute nothing.
  assign x_p = PAD'(x);
  assign p_p = PAD'(w_pos);
  assign n_p = PAD'(w_neg);

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    assign pos_cnt[s] = popcount32(x_p[32*s +: 32] & p_p[32*s +: 32] & ~n_p[32*s +: 32]);
    assign neg_cnt[s] = popcount32(x_p[32*s +: 32] & n_p[32*s +: 32] & ~p_p[32*s +: 32]);
  end

  always_comb begin
    sum = '0;
    for (int s = 0; s < SLICES; s++) begin
      sum = sum + OUT_BITS'(pos_cnt[s]) - OUT_BITS'(neg_cnt[s]);
    end
  end

  assign expected = sum;

endmodule
`default_nettype wire

// File: rtl/ternary_dot_driver.sv
`default_nettype none
//==============================================================================
// ternary_dot_driver: serializes one ternary job onto the tile bus and captures the result.
// Optional self-check macro: TERNARY_DOT_DRIVER_SELFCHECK_EN.  Rev 1.0
//==============================================================================
module ternary_dot_driver
  import ternary_dot_pkg::*;
#(
  parameter int N_ELEMS        = 32,
  parameter int RESULT_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_ELEMS-1:0]  x_vec,
  input  logic [N_ELEMS-1:0]  w_pos,
  input  logic [N_ELEMS-1:0]  w_neg,
  output logic [7:0]          dut_ui_in,
  output logic [7:0]          dut_uio_in,
  input  logic [7:0]          dut_uo_out,
  input  logic [7:0]          dut_uio_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OUT_BITS-1:0] res_data,
  output logic                busy,
  output logic                mismatch
);

  localparam int X_BEATS = N_ELEMS / 8;
  localparam int W_BEATS = N_ELEMS / 4;
  localparam int CNT_MAX = (W_BEATS > RESULT_LATENCY) ? W_BEATS : RESULT_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_BEATS - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_BEATS - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(RESULT_LATENCY - 1);

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [N_ELEMS-1:0]    x_sh, x_sh_nx;
  logic [2*N_ELEMS-1:0]  w_sh, w_sh_nx;
  logic [2*N_ELEMS-1:0]  w_codes;
  logic [7:0]            ui_q, ui_nx;
  logic [1:0]            ph_q, ph_nx;
  logic [OUT_BITS-1:0]   res_q;
  logic [OUT_BITS-1:0]   res_raw;
  logic                  accept;
  logic                  capture;
  logic                  leaving_result;
  logic                  unused_bits;

  // Conflicting +1/-1 masks on one element encode as zero weight.
  for (genvar i = 0; i < N_ELEMS; i++) begin : g_code
    assign w_codes[2*i +: 2] = (w_pos[i] && !w_neg[i]) ? W_POS :
                               (w_neg[i] && !w_pos[i]) ? W_NEG : W_ZERO;
  end

  assign res_raw     = {{(OUT_BITS-RES_BITS){dut_uio_out[7]}}, dut_uio_out[6:2], dut_uo_out};
  assign unused_bits = ^dut_uio_out[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Bus outputs are computed for the state being entered so each beat is registered.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    x_sh_nx        = x_sh;
    w_sh_nx        = w_sh;
    ui_nx          = ui_q;
    ph_nx          = ph_q;
    accept         = 1'b0;
    capture        = 1'b0;
    leaving_result = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = ST_LOAD_X;
          cnt_nx   = '0;
          ui_nx    = x_vec[7:0];
          ph_nx    = PH_X;
          x_sh_nx  = x_vec >> 8;
          w_sh_nx  = w_codes;
        end
      end
      ST_LOAD_X: begin
        if (cnt == X_LAST) begin
          state_nx = ST_LOAD_W;
          cnt_nx   = '0;
          ui_nx    = w_sh[7:0];
          ph_nx    = PH_W;
          w_sh_nx  = w_sh >> 8;
        end else begin
          cnt_nx   = cnt + 1'b1;
          ui_nx    = x_sh[7:0];
          x_sh_nx  = x_sh >> 8;
        end
      end
      ST_LOAD_W: begin
        if (cnt == W_LAST) begin
          state_nx = ST_WAIT;
          cnt_nx   = '0;
          ui_nx    = 8'h00;
          ph_nx    = PH_IDLE;
        end else begin
          cnt_nx   = cnt + 1'b1;
          ui_nx    = w_sh[7:0];
          w_sh_nx  = w_sh >> 8;
        end
      end
      ST_WAIT: begin
        if (cnt == L_LAST) begin
          capture  = 1'b1;
          state_nx = ST_RESULT;
        end else begin
          cnt_nx   = cnt + 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          leaving_result = 1'b1;
          state_nx       = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        ui_nx    = 8'h00;
        ph_nx    = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      x_sh  <= '0;
      w_sh  <= '0;
      ui_q  <= 8'h00;
      ph_q  <= PH_IDLE;
      res_q <= '0;
    end else begin
      cnt  <= cnt_nx;
      x_sh <= x_sh_nx;
      w_sh <= w_sh_nx;
      ui_q <= ui_nx;
      ph_q <= ph_nx;
      if (capture) begin
        res_q <= res_raw;
      end
    end
  end

`ifdef TERNARY_DOT_DRIVER_SELFCHECK_EN
  logic [OUT_BITS-1:0] expected_now;
  logic [OUT_BITS-1:0] expected_q;
  logic                mismatch_q;

  ternary_dot_ref #(
    .N_ELEMS (N_ELEMS)
  ) u_ref (
    .x        (x_vec),
    .w_pos    (w_pos),
    .w_neg    (w_neg),
    .expected (expected_now)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (accept) begin
        expected_q <= expected_now;
      end
      if (capture) begin
        mismatch_q <= (res_raw != expected_q);
      end else if (leaving_result) begin
        mismatch_q <= 1'b0;
      end
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign dut_ui_in  = ui_q;
  assign dut_uio_in = {6'b000000, ph_q};
  assign in_ready   = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign res_valid  = (state == ST_RESULT);
  assign res_data   = res_q;

endmodule
`default_nettype wire

// File: tb/tb_ternary_dot_driver.sv
`default_nettype none
//==============================================================================
// tb_ternary_dot_driver: randomized jobs against a behavioural tile/driver model with scoreboard
// Rev 1.0
//==============================================================================
module tb_ternary_dot_driver;

  localparam int N  = 32;
  localparam int L  = 2;
  localparam int XB = N / 8;
  localparam int WB = N / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] x_vec = '0;
  logic [N-1:0] w_pos = '0;
  logic [N-1:0] w_neg = '0;
  logic [7:0]   dut_ui_in;
  logic [7:0]   dut_uio_in;
  logic [7:0]   dut_uo_out = 8'h00;
  logic [7:0]   dut_uio_out = 8'h00;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [15:0]  res_data;
  logic         busy;
  logic         mismatch;

  ternary_dot_driver #(
    .N_ELEMS        (N),
    .RESULT_LATENCY (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x_vec       (x_vec),
    .w_pos       (w_pos),
    .w_neg       (w_neg),
    .dut_ui_in   (dut_ui_in),
    .dut_uio_in  (dut_uio_in),
    .dut_uo_out  (dut_uo_out),
    .dut_uio_out (dut_uio_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .mismatch    (mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] wp;
    logic [N-1:0] wn;
    int           r;
    int           acc;
  } job_t;

  job_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   force_hold = -1;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int ref_dot(input logic [N-1:0] x, input logic [N-1:0] wp, input logic [N-1:0] wn);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      if (x[i] && wp[i] && !wn[i]) s = s + 1;
      if (x[i] && wn[i] && !wp[i]) s = s - 1;
    end
    return s;
  endfunction

  function automatic logic [2*N-1:0] ref_codes(input logic [N-1:0] wp, input logic [N-1:0] wn);
    logic [2*N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (wp[i] && !wn[i])      c[2*i +: 2] = 2'b01;
      else if (wn[i] && !wp[i]) c[2*i +: 2] = 2'b11;
    end
    return c;
  endfunction

  // Tile model: presents a chosen signed result on uo_out/uio_out[7:2]; uio_out[1:0] is junk.
  task automatic set_tile(input int r);
    logic [15:0] v;
    v = 16'(r);
    dut_uo_out  = v[7:0];
    dut_uio_out = {v[13:8], 2'($urandom_range(0, 3))};
  endtask

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] wp, input logic [N-1:0] wn,
                       input int r, input bit noise);
    int   t;
    job_t j;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", 64'(in_ready), 64'd1);
      return;
    end
    set_tile(r);
    x_vec = x; w_pos = wp; w_neg = wn;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    j.x = x; j.wp = wp; j.wn = wn; j.r = r; j.acc = cyc;
    sb.push_back(j);
    in_valid = 1'b0;
    if (noise) begin
      for (int k = 0; k <= XB + WB + L; k++) begin
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        x_vec = $urandom; w_pos = $urandom; w_neg = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin : monitor
    logic [N-1:0]   xrec;
    logic [2*N-1:0] crec;
    int             xi, wi, xfirst, wfirst, hold;
    bit             prev_valid, hs_prev;
    logic [15:0]    prev_data;
    logic           prev_mm, exp_mm;
    job_t           j;
    xrec = '0; crec = '0; xi = 0; wi = 0; xfirst = 0; wfirst = 0; hold = 0;
    prev_valid = 0; hs_prev = 0; prev_data = '0; prev_mm = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        xi = 0; wi = 0; prev_valid = 0; hs_prev = 0; res_ready = 1'b0;
        continue;
      end
      check(dut_uio_in[7:2] == 6'd0, "uio_hi_zero", 64'(dut_uio_in), 64'(dut_uio_in[1:0]));
      check(in_ready == !busy, "in_ready_vs_busy", 64'(in_ready), 64'(!busy));
      if (hs_prev) begin
        check(in_ready && !res_valid && !busy, "idle_after_handshake",
              {61'd0, in_ready, res_valid, busy}, 64'd4);
      end
      hs_prev = 0;
      case (dut_uio_in[1:0])
        2'b01: begin
          if (xi == 0) xfirst = cyc;
          if (xi < XB) xrec[8*xi +: 8] = dut_ui_in;
          xi++;
        end
        2'b10: begin
          if (wi == 0) wfirst = cyc;
          if (wi < WB) crec[8*wi +: 8] = dut_ui_in;
          wi++;
        end
        2'b00: check(dut_ui_in == 8'h00, "ui_zero_no_phase", 64'(dut_ui_in), 64'd0);
        default: check(1'b0, "bad_phase", 64'(dut_uio_in), 64'd0);
      endcase
      if (res_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_result", 64'(res_data), 64'd0);
        end else begin
          j = sb.pop_front();
`ifdef TERNARY_DOT_DRIVER_SELFCHECK_EN
          exp_mm = (j.r != ref_dot(j.x, j.wp, j.wn));
`else
          exp_mm = 1'b0;
`endif
          check(xi == XB, "x_beat_count", 64'(xi), 64'(XB));
          check(wi == WB, "w_beat_count", 64'(wi), 64'(WB));
          check(xfirst == j.acc, "x_first_cycle", 64'(xfirst), 64'(j.acc));
          check(wfirst == j.acc + XB, "w_first_cycle", 64'(wfirst), 64'(j.acc + XB));
          check(xrec == j.x, "x_payload", 64'(xrec), 64'(j.x));
          check(crec == ref_codes(j.wp, j.wn), "w_payload", crec, ref_codes(j.wp, j.wn));
          check(cyc == j.acc + XB + WB + L, "result_latency", 64'(cyc), 64'(j.acc + XB + WB + L));
          check(res_data == 16'(j.r), "res_data", 64'(res_data), 64'(16'(j.r)));
          check(mismatch == exp_mm, "mismatch", 64'(mismatch), 64'(exp_mm));
        end
        xi = 0; wi = 0;
        hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
        force_hold = -1;
      end else if (res_valid) begin
        check(res_data == prev_data, "res_data_stable", 64'(res_data), 64'(prev_data));
        check(mismatch == prev_mm, "mismatch_stable", 64'(mismatch), 64'(prev_mm));
      end
      if (res_valid) begin
        if (hold == 0) begin
          res_ready = 1'b1;
          hs_prev = 1;
        end else begin
          res_ready = 1'b0;
          hold--;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
      prev_valid = res_valid;
      prev_data  = res_data;
      prev_mm    = mismatch;
    end
  end

  initial begin : stimulus
    logic [N-1:0] x, wp, wn;
    int           r, acc, t;
    #7;
    check(dut_ui_in == 8'h00, "rst_ui", 64'(dut_ui_in), 64'd0);
    check(dut_uio_in == 8'h00, "rst_uio", 64'(dut_uio_in), 64'd0);
    check(!res_valid && !busy && !mismatch, "rst_flags", {61'd0, res_valid, busy, mismatch}, 64'd0);
    check(res_data == 16'h0000, "rst_res_data", 64'(res_data), 64'd0);
    check(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    issue('1, '1, '0, 32, 1'b1);
    issue(32'h0000_00A5, 32'h1, 32'h2, ref_dot(32'hA5, 32'h1, 32'h2), 1'b1);
    issue('1, '1, '1, -32, 1'b1);
    force_hold = 5;
    issue(32'h0000_007F, 32'h0000_007F, 32'h0, 7, 1'b1);
    issue(32'h0000_007F, 32'h0000_007F, 32'h0, 5, 1'b1);

    // Reset mid-job during W beat 3; the partial job must vanish.
    issue($urandom, $urandom, $urandom, 11, 1'b0);
    acc = sb[$].acc;
    t = 0;
    while (cyc < acc + XB + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(dut_uio_in[1:0] == 2'b10, "pre_reset_w_phase", 64'(dut_uio_in), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check(dut_ui_in == 8'h00 && dut_uio_in == 8'h00, "async_rst_bus", {48'd0, dut_ui_in, dut_uio_in}, 64'd0);
    check(!busy && !res_valid && in_ready, "async_rst_state", {61'd0, busy, res_valid, in_ready}, 64'd1);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    for (int n = 0; n < 24; n++) begin
      x = $urandom; wp = $urandom; wn = $urandom;
      if (n % 3 == 0) wn = wn & ~wp;
      if ($urandom_range(0, 1) != 0) r = ref_dot(x, wp, wn);
      else r = int'($urandom_range(0, 8191)) - 4096;
      issue(x, wp, wn, r, 1'b1);
    end

    t = 0;
    while ((sb.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(sb.size() == 0 && !busy, "drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
